// File: rtl/simd_upstream_multi_intf.sv
// SIMD register file to stack-upstream bridge: snapshots masked lane registers and
// serialises them as SOM/MOM/EOM beats through a small flow-controlled output FIFO.
module simd_upstream_multi_intf #(
  parameter int NUM_LANES                  = 32,
  parameter int LANE_WIDTH                 = 32,
  parameter int UP_DATA_WIDTH              = 64,
  parameter int TAG_WIDTH                  = 8,
  parameter int FIFO_DEPTH                 = 8,
  parameter int FIFO_THRESHOLD             = 2,
  parameter int COMMON_STD_INTF_CNTL_WIDTH = 2,
  parameter int STACK_UP_INTF_TYPE_WIDTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_poweron,
  input  logic [NUM_LANES*LANE_WIDTH-1:0]       simd__sui__regs,
  input  logic [NUM_LANES-1:0]                  simd__sui__regs_valid,
  input  logic [NUM_LANES-1:0]                  simd__sui__lane_enable,
  input  logic                                  simd__sui__scalar,
  input  logic [TAG_WIDTH-1:0]                  simd__sui__tag,
  output logic                                  sui__simd__regs_ready,
  output logic                                  sui__simd__regs_complete,
  output logic                                  sui__sti__valid,
  output logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] sui__sti__cntl,
  output logic [STACK_UP_INTF_TYPE_WIDTH-1:0]   sui__sti__type,
  output logic [UP_DATA_WIDTH-1:0]              sui__sti__data,
  output logic [TAG_WIDTH-1:0]                  sui__sti__oob_data,
  input  logic                                  sti__sui__ready
);
  localparam logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] CNTL_MOM     = 'd0;
  localparam logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] CNTL_SOM     = 'd1;
  localparam logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] CNTL_EOM     = 'd2;
  localparam logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] CNTL_SOM_EOM = 'd3;
  localparam logic [STACK_UP_INTF_TYPE_WIDTH-1:0]   TYPE_NA      = 'd0;
  localparam logic [STACK_UP_INTF_TYPE_WIDTH-1:0]   TYPE_DATA    = 'd1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int LPB    = UP_DATA_WIDTH / LANE_WIDTH;
  localparam int NBEATS = NUM_LANES / LPB;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = COMMON_STD_INTF_CNTL_WIDTH + STACK_UP_INTF_TYPE_WIDTH + UP_DATA_WIDTH + TAG_WIDTH;
  localparam int RW     = NUM_LANES * LANE_WIDTH;

  logic [RW-1:0]        r_regs_d1, r_snap, w_masked, w_src;
  logic [NUM_LANES-1:0] r_valid_d1, r_en_d1;
  logic                 r_scalar_d1, r_snap_scalar, r_rdy_d1;
  logic [TAG_WIDTH-1:0] r_tag_d1, r_snap_tag, w_tag;
  logic [1:0]           r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt, w_idx;
  logic                 w_start, w_wr, w_rd, w_afull, w_scalar, w_last;
  logic [UP_DATA_WIDTH-1:0]              w_data;
  logic [COMMON_STD_INTF_CNTL_WIDTH-1:0] w_cntl;
  logic [STACK_UP_INTF_TYPE_WIDTH-1:0]   w_type;
  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_occ;

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_regs_d1   <= '0;
      r_valid_d1  <= '0;
      r_en_d1     <= '0;
      r_scalar_d1 <= 1'b0;
      r_tag_d1    <= '0;
      r_rdy_d1    <= 1'b0;
    end else begin
      r_regs_d1   <= simd__sui__regs;
      r_valid_d1  <= simd__sui__regs_valid;
      r_en_d1     <= simd__sui__lane_enable;
      r_scalar_d1 <= simd__sui__scalar;
      r_tag_d1    <= simd__sui__tag;
      r_rdy_d1    <= sti__sui__ready;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_mask
    assign w_masked[g*LANE_WIDTH +: LANE_WIDTH] = r_en_d1[g] ? r_regs_d1[g*LANE_WIDTH +: LANE_WIDTH] : '0;
  end

  assign w_afull = (r_occ >= (AW+1)'(FIFO_DEPTH - FIFO_THRESHOLD));
  assign w_start = (r_state == IDLE) && (|r_en_d1) &&
                   ((r_valid_d1 & r_en_d1) == r_en_d1) && !w_afull;
  assign w_wr    = w_start || ((r_state == SEND) && !w_afull);
  assign w_rd    = r_rdy_d1 && (r_occ != '0);

  // Beat 0 is built straight from the registered inputs; later beats come from the snapshot.
  always_comb begin
    w_src    = w_start ? w_masked : r_snap;
    w_scalar = w_start ? r_scalar_d1 : r_snap_scalar;
    w_tag    = w_start ? r_tag_d1 : r_snap_tag;
    w_idx    = (r_state == IDLE) ? '0 : r_cnt;
    w_data   = w_src[w_idx*UP_DATA_WIDTH +: UP_DATA_WIDTH];
    if (w_scalar) begin
      w_data = '0;
      w_data[LANE_WIDTH-1:0] = w_src[LANE_WIDTH-1:0];
    end
    w_last = w_scalar || (w_idx == CW'(NBEATS-1));
    w_type = (w_idx == '0) ? TYPE_DATA : TYPE_NA;
    if (w_idx == '0) w_cntl = w_last ? CNTL_SOM_EOM : CNTL_SOM;
    else             w_cntl = w_last ? CNTL_EOM : CNTL_MOM;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_start) begin
        w_state_nxt = (r_scalar_d1 || NBEATS == 1) ? DONE : SEND;
        w_cnt_nxt   = CW'(1);
      end
      SEND: if (!w_afull) begin
        if (r_cnt == CW'(NBEATS-1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_cnt_nxt = '0;
        if ((r_valid_d1 & r_en_d1) == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_state                  <= IDLE;
      r_cnt                    <= '0;
      r_snap                   <= '0;
      r_snap_tag               <= '0;
      r_snap_scalar            <= 1'b0;
      sui__simd__regs_ready    <= 1'b0;
      sui__simd__regs_complete <= 1'b0;
    end else begin
      r_state                  <= w_state_nxt;
      r_cnt                    <= w_cnt_nxt;
      sui__simd__regs_ready    <= (w_state_nxt == IDLE);
      sui__simd__regs_complete <= (w_state_nxt != IDLE);
      if (w_start) begin
        r_snap        <= w_masked;
        r_snap_tag    <= r_tag_d1;
        r_snap_scalar <= r_scalar_d1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {w_cntl, w_type, w_data, w_tag};
        r_wp        <= (r_wp == AW'(FIFO_DEPTH-1)) ? '0 : r_wp + AW'(1);
      end
      if (w_rd) r_rp <= (r_rp == AW'(FIFO_DEPTH-1)) ? '0 : r_rp + AW'(1);
      r_occ <= r_occ + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  assign sui__sti__valid = w_rd;
  assign {sui__sti__cntl, sui__sti__type, sui__sti__data, sui__sti__oob_data} = r_mem[r_rp];
endmodule

// File: tb/tb_simd_upstream_multi_intf.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_simd_upstream_multi_intf;
  localparam int NL = 32, LW = 32, DW = 64, TW = 8;
  localparam logic [1:0] MOM = 2'd0, SOM = 2'd1, EOM = 2'd2, SOM_EOM = 2'd3;
  localparam logic [1:0] T_NA = 2'd0, T_DATA = 2'd1;

  typedef struct packed {
    logic [1:0]    cntl;
    logic [1:0]    typ;
    logic [DW-1:0] data;
    logic [TW-1:0] oob;
  } beat_t;

  logic              clk = 1'b0, reset_poweron = 1'b0;
  logic [NL*LW-1:0]  simd__sui__regs = '0;
  logic [NL-1:0]     simd__sui__regs_valid = '0, simd__sui__lane_enable = '0;
  logic              simd__sui__scalar = 1'b0;
  logic [TW-1:0]     simd__sui__tag = '0;
  logic              sui__simd__regs_ready, sui__simd__regs_complete, sui__sti__valid;
  logic [1:0]        sui__sti__cntl, sui__sti__type;
  logic [DW-1:0]     sui__sti__data;
  logic [TW-1:0]     sui__sti__oob_data;
  logic              sti__sui__ready = 1'b1;

  simd_upstream_multi_intf dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .simd__sui__regs(simd__sui__regs), .simd__sui__regs_valid(simd__sui__regs_valid),
    .simd__sui__lane_enable(simd__sui__lane_enable), .simd__sui__scalar(simd__sui__scalar),
    .simd__sui__tag(simd__sui__tag), .sui__simd__regs_ready(sui__simd__regs_ready),
    .sui__simd__regs_complete(sui__simd__regs_complete), .sui__sti__valid(sui__sti__valid),
    .sui__sti__cntl(sui__sti__cntl), .sui__sti__type(sui__sti__type),
    .sui__sti__data(sui__sti__data), .sui__sti__oob_data(sui__sti__oob_data),
    .sti__sui__ready(sti__sui__ready)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  logic [31:0] lanes [NL];
  int n_tests = 0, n_fail = 0, n_beats = 0, n_eom = 0;

  always @(negedge clk) begin
    if (reset_poweron && sui__sti__valid) begin
      beat_t act, e;
      act = '{sui__sti__cntl, sui__sti__type, sui__sti__data, sui__sti__oob_data};
      n_tests++;
      n_beats++;
      if (act.cntl == EOM || act.cntl == SOM_EOM) n_eom++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got %h, expected no beat", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL beat: got cntl=%0d type=%0d data=%h oob=%h, expected cntl=%0d type=%0d data=%h oob=%h",
                   act.cntl, act.typ, act.data, act.oob, e.cntl, e.typ, e.data, e.oob);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // sel 0: regs_ready, 1: regs_complete, 2: scoreboard drained
  task automatic wait_for(input int sel, input string nm);
    int c = 0;
    bit ok = 0;
    while (c < 300) begin
      ok = (sel == 0) ? sui__simd__regs_ready : (sel == 1) ? sui__simd__regs_complete : (exp_q.size() == 0);
      if (ok) break;
      tick();
      c++;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_%s: condition not met, expected within 300 cycles", nm);
    end
  endtask

  task automatic push_msg(input logic [NL-1:0] en, input bit scalar, input logic [TW-1:0] tag);
    beat_t e;
    if (scalar) begin
      e = '{SOM_EOM, T_DATA, {32'h0, en[0] ? lanes[0] : 32'h0}, tag};
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < NL/2; k++) begin
        e.data = {en[2*k+1] ? lanes[2*k+1] : 32'h0, en[2*k] ? lanes[2*k] : 32'h0};
        e.cntl = (k == 0) ? SOM : (k == NL/2-1) ? EOM : MOM;
        e.typ  = (k == 0) ? T_DATA : T_NA;
        e.oob  = tag;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_regs();
    for (int i = 0; i < NL; i++) simd__sui__regs[i*LW +: LW] = lanes[i];
  endtask

  task automatic send_msg(input logic [NL-1:0] en, input bit scalar, input logic [TW-1:0] tag);
    wait_for(0, "regs_ready");
    drive_regs();
    simd__sui__lane_enable = en;
    simd__sui__scalar      = scalar;
    simd__sui__tag         = tag;
    simd__sui__regs_valid  = '1;
    push_msg(en, scalar, tag);
    wait_for(1, "complete");
    simd__sui__regs_valid = '0;
  endtask

  initial begin
    int b0, e0, vcnt;
    for (int i = 0; i < NL; i++) lanes[i] = i;
    #2;
    check("reset_ready", {63'h0, sui__simd__regs_ready}, 64'h0);
    check("reset_valid", {63'h0, sui__sti__valid}, 64'h0);
    check("reset_complete", {63'h0, sui__simd__regs_complete}, 64'h0);
    tick(2);
    reset_poweron = 1'b1;
    tick();
    check("ready_after_release", {63'h0, sui__simd__regs_ready}, 64'h1);

    // full vector, lane i = i
    b0 = n_beats; e0 = n_eom;
    send_msg('1, 1'b0, 8'hA5);
    wait_for(2, "drain_vec");
    tick(2);
    check("vec_beats", n_beats - b0, 16);
    check("vec_eoms", n_eom - e0, 1);

    // scalar
    lanes[0] = 32'hDEADBEEF;
    b0 = n_beats;
    send_msg('1, 1'b1, 8'h3C);
    wait_for(2, "drain_scalar");
    wait_for(0, "scalar_idle");
    tick(2);
    check("scalar_beats", n_beats - b0, 1);

    // lane mask 0xF0
    for (int i = 0; i < NL; i++) lanes[i] = 32'h100 + i;
    send_msg(32'h0000_00F0, 1'b0, 8'h11);
    wait_for(2, "drain_mask");
    wait_for(0, "mask_idle");

    // zero enable never starts
    b0 = n_beats;
    simd__sui__lane_enable = '0;
    simd__sui__regs_valid  = '1;
    tick(30);
    check("zero_en_beats", n_beats - b0, 0);
    check("zero_en_ready", {63'h0, sui__simd__regs_ready}, 64'h1);
    simd__sui__regs_valid = '0;
    tick(2);

    // back-pressure mid-message
    for (int i = 0; i < NL; i++) lanes[i] = 32'hA000_0000 + i * 3;
    b0 = n_beats; e0 = n_eom;
    send_msg('1, 1'b0, 8'h77);
    tick(3);
    sti__sui__ready = 1'b0;
    tick(2);
    vcnt = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (sui__sti__valid) vcnt++;
      #1;
    end
    check("stall_no_valid", vcnt, 0);
    sti__sui__ready = 1'b1;
    wait_for(2, "drain_stall");
    tick(2);
    check("stall_beats", n_beats - b0, 16);
    check("stall_eoms", n_eom - e0, 1);

    // reload right after complete: snapshot keeps message A intact
    for (int i = 0; i < NL; i++) lanes[i] = 32'h5000_0000 + i;
    b0 = n_beats;
    send_msg('1, 1'b0, 8'h01);
    for (int i = 0; i < NL; i++) lanes[i] = 32'h6000_0000 + i;
    drive_regs();
    send_msg('1, 1'b0, 8'h02);
    wait_for(2, "drain_reload");
    tick(2);
    check("reload_beats", n_beats - b0, 32);

    // async reset mid-SEND
    wait_for(0, "pre_reset_idle");
    sti__sui__ready = 1'b0;
    tick(2);
    for (int i = 0; i < NL; i++) lanes[i] = 32'hBEEF_0000 + i;
    drive_regs();
    simd__sui__lane_enable = '1;
    simd__sui__tag         = 8'h99;
    simd__sui__regs_valid  = '1;
    tick(5);
    #2;
    reset_poweron = 1'b0;
    #1;
    check("rst_valid", {63'h0, sui__sti__valid}, 64'h0);
    check("rst_data", sui__sti__data, 64'h0);
    check("rst_cntl_type_oob", {52'h0, sui__sti__cntl, sui__sti__type, sui__sti__oob_data}, 64'h0);
    check("rst_ready_complete", {62'h0, sui__simd__regs_ready, sui__simd__regs_complete}, 64'h0);
    simd__sui__regs_valid = '0;
    sti__sui__ready = 1'b1;
    tick(2);
    reset_poweron = 1'b1;
    b0 = n_beats;
    tick(6);
    check("post_reset_empty", n_beats - b0, 0);
    b0 = n_beats; e0 = n_eom;
    for (int i = 0; i < NL; i++) lanes[i] = 32'hC000_0000 + i;
    send_msg('1, 1'b0, 8'h42);
    wait_for(2, "drain_post_reset");
    tick(3);
    check("post_reset_beats", n_beats - b0, 16);
    check("post_reset_eoms", n_eom - e0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
